// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - opcode/funct constants, ALU ops and FSM states for the RV32I core
package rv32i_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_W    = 3'b010;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
   } alu_op_t;

   typedef logic [2:0] state_t;
   localparam state_t S_FETCH  = 3'd0;
   localparam state_t S_DECODE = 3'd1;
   localparam state_t S_EXEC   = 3'd2;
   localparam state_t S_MEM_RD = 3'd3;
   localparam state_t S_MEM_WR = 3'd4;
   localparam state_t S_WB     = 3'd5;

   // alt selects SUB/SRA over ADD/SRL
   function automatic alu_op_t alu_select(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32x32 register file, two async read ports, one sync write port, x0 reads 0
module rv32i_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [1:31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/rv32i_cpu_core.sv
// rtl/rv32i_cpu_core.sv - multi-cycle RV32I core on one shared bus
// Defining RV32I_BRANCH_EN adds BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR.
module rv32i_cpu_core #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in_BUS,
   input  logic        bus_full,
   output logic [31:0] data_out_BUS,
   output logic [31:0] address_out,
   output logic [31:0] result,
   output logic [31:0] imm_32,
   output logic [31:0] reg1,
   output logic [31:0] reg2,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        memToReg_flipflop,
   output logic [31:0] data_cpu_o,
   output logic [31:0] read_address,
   output logic        instr_wait,
   output logic [31:0] reg_write,
   output logic        reg_write_en
);
   import rv32i_pkg::*;

   state_t      state;
   logic [31:0] pc, ir, result_q, load_q, next_pc_q;
   logic        mem_to_reg_q;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] imm, imm_i, imm_s, imm_u, operand_b, alu_out, pc_plus4, next_pc;
   alu_op_t     alu_op;
   logic        use_imm, writes_rd, mem_rd, mem_wr, link_sel;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign rd     = ir[11:7];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_u  = {ir[31:12], 12'd0};

`ifdef RV32I_BRANCH_EN
   logic [31:0] imm_b, imm_j;
   logic        is_jal, is_jalr, is_branch, branch_taken;
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
`endif

   // Anything not decoded here falls through as a NOP that still passes WB to advance the PC
   always_comb begin
      imm       = '0;
      alu_op    = ALU_ADD;
      use_imm   = 1'b1;
      writes_rd = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
`ifdef RV32I_BRANCH_EN
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
`endif
      case (opcode)
         OP_REG: begin
            use_imm   = 1'b0;
            alu_op    = alu_select(funct3, funct7[5]);
            writes_rd = (funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
         end
         OP_IMM: begin
            imm    = imm_i;
            alu_op = alu_select(funct3, funct3 == F3_SR && funct7[5]);
            if (funct3 == F3_SLL)     writes_rd = (funct7 == F7_BASE);
            else if (funct3 == F3_SR) writes_rd = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else                      writes_rd = 1'b1;
         end
         OP_LOAD: begin
            imm       = imm_i;
            mem_rd    = (funct3 == F3_W);
            writes_rd = (funct3 == F3_W);
         end
         OP_STORE: begin
            imm    = imm_s;
            mem_wr = (funct3 == F3_W);
         end
         OP_LUI: begin
            imm       = imm_u;
            alu_op    = ALU_PASS_B;
            writes_rd = 1'b1;
         end
`ifdef RV32I_BRANCH_EN
         OP_JAL: begin
            imm       = imm_j;
            is_jal    = 1'b1;
            writes_rd = 1'b1;
         end
         OP_JALR: begin
            imm       = imm_i;
            is_jalr   = (funct3 == 3'b000);
            writes_rd = (funct3 == 3'b000);
         end
         OP_BRANCH: begin
            imm       = imm_b;
            is_branch = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign operand_b = use_imm ? imm : reg2;

   always_comb begin
      case (alu_op)
         ALU_ADD:    alu_out = reg1 + operand_b;
         ALU_SUB:    alu_out = reg1 - operand_b;
         ALU_AND:    alu_out = reg1 & operand_b;
         ALU_OR:     alu_out = reg1 | operand_b;
         ALU_XOR:    alu_out = reg1 ^ operand_b;
         ALU_SLL:    alu_out = reg1 << operand_b[4:0];
         ALU_SRL:    alu_out = reg1 >> operand_b[4:0];
         ALU_SRA:    alu_out = $unsigned($signed(reg1) >>> operand_b[4:0]);
         ALU_SLT:    alu_out = {31'd0, $signed(reg1) < $signed(operand_b)};
         ALU_SLTU:   alu_out = {31'd0, reg1 < operand_b};
         ALU_PASS_B: alu_out = operand_b;
         default:    alu_out = '0;
      endcase
   end

   assign pc_plus4 = pc + 32'd4;

`ifdef RV32I_BRANCH_EN
   always_comb begin
      case (funct3)
         F3_BEQ:  branch_taken = (reg1 == reg2);
         F3_BNE:  branch_taken = (reg1 != reg2);
         F3_BLT:  branch_taken = ($signed(reg1) < $signed(reg2));
         F3_BGE:  branch_taken = ($signed(reg1) >= $signed(reg2));
         F3_BLTU: branch_taken = (reg1 < reg2);
         F3_BGEU: branch_taken = (reg1 >= reg2);
         default: branch_taken = 1'b0;
      endcase
   end
   assign next_pc  = (is_jal || (is_branch && branch_taken)) ? pc + imm :
                     is_jalr ? ((reg1 + imm) & ~32'd1) : pc_plus4;
   assign link_sel = is_jal | is_jalr;
`else
   assign next_pc  = pc_plus4;
   assign link_sel = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         ir           <= '0;
         result_q     <= '0;
         load_q       <= '0;
         next_pc_q    <= RESET_PC;
         mem_to_reg_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH: if (bus_full) begin
               ir    <= data_in_BUS;
               state <= S_DECODE;
            end
            S_DECODE: begin
               mem_to_reg_q <= mem_rd;
               state        <= S_EXEC;
            end
            S_EXEC: begin
               result_q  <= link_sel ? pc_plus4 : alu_out;
               next_pc_q <= next_pc;
               state     <= mem_rd ? S_MEM_RD : (mem_wr ? S_MEM_WR : S_WB);
            end
            S_MEM_RD: if (bus_full) begin
               load_q <= data_in_BUS;
               state  <= S_WB;
            end
            S_MEM_WR: begin
               pc    <= next_pc_q;
               state <= S_FETCH;
            end
            S_WB: begin
               pc    <= next_pc_q;
               state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   rv32i_regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .wa  (rd),
      .we  (reg_write_en),
      .wd  (reg_write),
      .rd1 (reg1),
      .rd2 (reg2)
   );

   assign imm_32            = imm;
   assign result            = result_q;
   assign memToReg_flipflop = mem_to_reg_q;
   assign read_address      = reg1 + imm;
   assign data_cpu_o        = reg2;
   assign instr_wait        = (state == S_FETCH);
   assign address_out       = (state == S_MEM_RD || state == S_MEM_WR) ? read_address : pc;
   assign data_out_BUS      = (state == S_MEM_WR) ? reg2 : 32'd0;
   assign reg_write         = mem_to_reg_q ? load_q : result_q;
   assign reg_write_en      = (state == S_WB) && writes_rd && (rd != 5'd0);

endmodule

// File: tb/tb_rv32i_cpu_core.sv
// tb/tb_rv32i_cpu_core.sv - directed bench for rv32i_cpu_core with a writeback scoreboard
module tb_rv32i_cpu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in_BUS;
   logic        bus_full;
   logic [31:0] data_out_BUS, address_out, result, imm_32, reg1, reg2;
   logic [4:0]  rs1, rs2, rd;
   logic        memToReg_flipflop, instr_wait, reg_write_en;
   logic [31:0] data_cpu_o, read_address, reg_write;

   int checks = 0;
   int errors = 0;
   logic [36:0] wb_q[$];

   rv32i_cpu_core #(.RESET_PC(32'h0)) dut (
      .clk               (clk),
      .rst               (rst),
      .data_in_BUS       (data_in_BUS),
      .bus_full          (bus_full),
      .data_out_BUS      (data_out_BUS),
      .address_out       (address_out),
      .result            (result),
      .imm_32            (imm_32),
      .reg1              (reg1),
      .reg2              (reg2),
      .rs1               (rs1),
      .rs2               (rs2),
      .rd                (rd),
      .memToReg_flipflop (memToReg_flipflop),
      .data_cpu_o        (data_cpu_o),
      .read_address      (read_address),
      .instr_wait        (instr_wait),
      .reg_write         (reg_write),
      .reg_write_en      (reg_write_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every register write must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && reg_write_en) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected", 32'(reg_write_en), 32'd0);
         end else begin
            logic [36:0] e;
            e = wb_q.pop_front();
            check("wb_rd", 32'(rd), 32'(e[36:32]));
            check("wb_data", reg_write, e[31:0]);
         end
      end
   end

   task automatic wait_fetch(output int n);
      n = 0;
      while (!instr_wait && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic issue(input logic [31:0] instr, input logic [31:0] exp_pc);
      int n;
      wait_fetch(n);
      check("fetch_wait", 32'(instr_wait), 32'd1);
      check("fetch_pc", address_out, exp_pc);
      data_in_BUS = instr;
      bus_full    = 1'b1;
      @(negedge clk);
      bus_full    = 1'b0;
      data_in_BUS = '0;
   endtask

   logic [31:0] alu_instr [8] = '{32'h40308333, 32'h40435393, 32'h0060B433, 32'h0060A4B3,
                                  32'h12345537, 32'h01F09593, 32'h0F037713, 32'h00B567B3};
   logic [4:0]  alu_rd    [8] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd14, 5'd15};
   logic [31:0] alu_exp   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0,
                                  32'h12345000, 32'h80000000, 32'h000000F0, 32'h92345000};

   initial begin
      int n;
      rst = 1'b1;
      bus_full = 1'b0;
      data_in_BUS = '0;
      @(negedge clk);
      check("rst_address", address_out, 32'd0);
      check("rst_instr_wait", 32'(instr_wait), 32'd1);
      check("rst_data_out", data_out_BUS, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_wb_en", 32'(reg_write_en), 32'd0);
      check("rst_mem_to_reg", 32'(memToReg_flipflop), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // LW x1,3(x4) with load data 1 after a held bus
      wb_q.push_back({5'd1, 32'd1});
      issue(32'h00322083, 32'd0);
      check("lw_rs1", 32'(rs1), 32'd4);
      check("lw_rd", 32'(rd), 32'd1);
      check("lw_imm", imm_32, 32'd3);
      @(negedge clk);
      check("lw_read_address", read_address, 32'd3);
      @(negedge clk);
      check("lw_mem_addr", address_out, 32'd3);
      check("lw_not_fetch", 32'(instr_wait), 32'd0);
      repeat (2) @(negedge clk);
      check("lw_hold_addr", address_out, 32'd3);
      data_in_BUS = 32'd1;
      bus_full = 1'b1;
      @(negedge clk);
      bus_full = 1'b0;
      data_in_BUS = '0;
      check("lw_mem_to_reg", 32'(memToReg_flipflop), 32'd1);
      check("lw_wb_en", 32'(reg_write_en), 32'd1);
      wait_fetch(n);

      // ADDI x2,x0,1
      wb_q.push_back({5'd2, 32'd1});
      issue(32'h00100113, 32'd4);
      wait_fetch(n);
      check("addi_latency_ok", 32'(n + 1 <= 4), 32'd1);

      // ADD x3,x2,x1
      wb_q.push_back({5'd3, 32'd2});
      issue(32'h001101B3, 32'd8);
      check("add_reg1", reg1, 32'd1);
      check("add_reg2", reg2, 32'd1);
      repeat (2) @(negedge clk);
      check("add_result", result, 32'd2);
      check("add_mem_to_reg", 32'(memToReg_flipflop), 32'd0);
      wait_fetch(n);

      // SW x1,97(x2), with a stray bus_full in EXEC
      issue(32'h061120A3, 32'd12);
      check("sw_imm", imm_32, 32'd97);
      check("sw_data_cpu", data_cpu_o, 32'd1);
      @(negedge clk);
      check("sw_exec_data_out", data_out_BUS, 32'd0);
      data_in_BUS = 32'hDEADBEEF;
      bus_full = 1'b1;
      @(negedge clk);
      bus_full = 1'b0;
      data_in_BUS = '0;
      check("sw_addr", address_out, 32'd98);
      check("sw_data_out", data_out_BUS, 32'd1);
      check("sw_no_wb", 32'(reg_write_en), 32'd0);
      @(negedge clk);
      check("sw_data_out_clear", data_out_BUS, 32'd0);
      check("sw_back_to_fetch", 32'(instr_wait), 32'd1);

      // ADDI x0,x0,5 and an unsupported word: no writes, PC still advances
      issue(32'h00500013, 32'd16);
      wait_fetch(n);
      issue(32'hFFFFFFFF, 32'd20);
      wait_fetch(n);
      wb_q.push_back({5'd5, 32'd2});
      issue(32'h003002B3, 32'd24);
      check("x0_reads_zero", reg1, 32'd0);
      wait_fetch(n);

      for (int i = 0; i < 8; i++) begin
         wb_q.push_back({alu_rd[i], alu_exp[i]});
         issue(alu_instr[i], 32'd28 + 32'(4 * i));
         wait_fetch(n);
      end

      // LW x12,0(x0) interrupted by reset in MEM_RD
      issue(32'h00002603, 32'd60);
      repeat (2) @(negedge clk);
      check("rst_mid_in_mem_rd", 32'(instr_wait), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_fetch", 32'(instr_wait), 32'd1);
      check("rst_mid_pc", address_out, 32'd0);
      check("rst_mid_mem_to_reg", 32'(memToReg_flipflop), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ADD x13,x12,x1: both sources cleared by the reset
      wb_q.push_back({5'd13, 32'd0});
      issue(32'h001606B3, 32'd0);
      check("post_rst_x12", reg1, 32'd0);
      check("post_rst_x1", reg2, 32'd0);
      wait_fetch(n);
      check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
